// File: rtl/sync_frame_pkg.sv
// Shared types and constants for the sync-word framed serial receiver.
package sync_frame_pkg;

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_PARITY  = 2'd2
   } state_t;

   localparam int             DEFAULT_PAT_W   = 5;
   localparam logic [4:0]     DEFAULT_PATTERN = 5'b11011;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/seq_detect_moore.sv
// Overlapping Moore sequence detector; out is high the cycle after the last pattern bit.
module seq_detect_moore #(
   parameter int               PAT_W   = 5,
   parameter logic [PAT_W-1:0] PATTERN = 5'b11011
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic signal,
   output logic out
);

   logic [PAT_W-1:0] hist;
   logic [PAT_W-1:0] fill;
   logic [PAT_W-1:0] hist_n;
   logic [PAT_W-1:0] fill_n;

   assign hist_n = {hist[PAT_W-2:0], signal};
   // fill tracks how many history bits are real, so a cleared history never matches zeros
   assign fill_n = {fill[PAT_W-2:0], 1'b1};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist <= '0;
         fill <= '0;
         out  <= 1'b0;
      end else if (clr) begin
         hist <= '0;
         fill <= '0;
         out  <= 1'b0;
      end else begin
         hist <= hist_n;
         fill <= fill_n;
         out  <= (&fill_n) && (hist_n == PATTERN);
      end
   end

endmodule

// File: rtl/sync_frame_ctrl.sv
// Sync-word framed serial receiver with valid/ready word output and overrun flag.
// Define PARITY_CHECK_EN to add an even-parity bit after each payload.
//
// state      | meaning
// ST_HUNT    | detector running, waiting for the sync pattern
// ST_PAYLOAD | shifting payload bits MSB-first
// ST_PARITY  | sampling the parity bit (PARITY_CHECK_EN only)
module sync_frame_ctrl
   import sync_frame_pkg::*;
#(
   parameter int               PAT_W   = DEFAULT_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEFAULT_PATTERN),
   parameter int               DATA_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              signal,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              sync_found,
   output logic              overrun,
   output logic              busy,
   output logic              parity_err
);

   localparam int                CNT_W    = clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);
`ifdef PARITY_CHECK_EN
   localparam state_t            ST_AFTER = ST_PARITY;
`else
   localparam state_t            ST_AFTER = ST_HUNT;
`endif

   state_t            state;
   logic [DATA_W-1:0] shreg;
   logic [CNT_W-1:0]  cnt;
   logic              det_clr;
   logic              det_hit;
   logic [DATA_W-1:0] word_next;
   logic              last_bit;
   logic              frame_done;
   logic              frame_good;
   logic [DATA_W-1:0] frame_word;

   assign det_clr = (state != ST_HUNT);

   seq_detect_moore #(
      .PAT_W   (PAT_W),
      .PATTERN (PATTERN)
   ) u_det (
      .clk    (clk),
      .rst    (rst),
      .clr    (det_clr),
      .signal (signal),
      .out    (det_hit)
   );

   assign word_next  = DATA_W'({shreg, signal});
   assign last_bit   = ((state == ST_PAYLOAD) && (cnt == LAST_CNT)) ||
                       ((state == ST_HUNT) && det_hit && (DATA_W == 1));
   assign sync_found = (state == ST_HUNT) && det_hit;

`ifdef PARITY_CHECK_EN
   assign frame_done = (state == ST_PARITY);
   assign frame_word = shreg;
   assign frame_good = ~(^{shreg, signal});
`else
   assign frame_done = last_bit;
   assign frame_word = word_next;
   assign frame_good = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_HUNT;
         shreg      <= '0;
         cnt        <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
         parity_err <= 1'b0;
         busy       <= 1'b0;
      end else begin
         overrun    <= 1'b0;
         parity_err <= 1'b0;
         if (data_valid && data_ready) data_valid <= 1'b0;

         // a word being read on the completing edge frees the slot for the new one
         if (frame_done) begin
            if (!frame_good) begin
               parity_err <= 1'b1;
            end else if (!data_valid || data_ready) begin
               data_out   <= frame_word;
               data_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end

         case (state)
            ST_HUNT: begin
               cnt <= '0;
               if (det_hit) begin
                  shreg <= word_next;
                  cnt   <= CNT_W'(1);
                  if (last_bit) begin
                     state <= ST_AFTER;
                     busy  <= (ST_AFTER != ST_HUNT);
                  end else begin
                     state <= ST_PAYLOAD;
                     busy  <= 1'b1;
                  end
               end
            end
            ST_PAYLOAD: begin
               shreg <= word_next;
               cnt   <= cnt + CNT_W'(1);
               if (last_bit) begin
                  state <= ST_AFTER;
                  busy  <= (ST_AFTER != ST_HUNT);
               end
            end
            ST_PARITY: begin
               state <= ST_HUNT;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_HUNT;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sync_frame_ctrl.sv
// Randomised and directed bench for sync_frame_ctrl against a bit-queue reference model.
module tb_sync_frame_ctrl;

   localparam int               PAT_W  = 5;
   localparam int               DATA_W = 8;
   localparam logic [PAT_W-1:0] PAT    = 5'b11011;
`ifdef PARITY_CHECK_EN
   localparam int               FRAME_LEN = DATA_W + 1;
`else
   localparam int               FRAME_LEN = DATA_W;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              signal = 1'b0;
   logic              data_ready = 1'b0;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              sync_found;
   logic              overrun;
   logic              busy;
   logic              parity_err;

   sync_frame_ctrl #(
      .PAT_W   (PAT_W),
      .PATTERN (PAT),
      .DATA_W  (DATA_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .signal     (signal),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .sync_found (sync_found),
      .overrun    (overrun),
      .busy       (busy),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: bits are kept as plain queues; a frame is the FRAME_LEN bits after a hit.
   logic [PAT_W-1:0]  pat_v = PAT;
   bit                hq[$];
   bit                pq[$];
   bit                m_hunt = 1'b1;
   bit                m_hit = 1'b0;
   bit                m_valid = 1'b0;
   logic [DATA_W-1:0] m_data = '0;
   bit                m_ovr = 1'b0;
   bit                m_perr = 1'b0;

   function automatic bit pat_hit();
      if (hq.size() < PAT_W) return 1'b0;
      for (int k = 0; k < PAT_W; k++)
         if (hq[hq.size() - PAT_W + k] != pat_v[PAT_W-1-k]) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_hunt = 1'b1; m_hit = 1'b0; m_valid = 1'b0; m_data = '0;
         m_ovr = 1'b0; m_perr = 1'b0;
         hq.delete(); pq.delete();
      end else begin
         bit s, r, consumed, loaded, par;
         logic [DATA_W-1:0] w;
         s = signal; r = data_ready;
         m_ovr = 1'b0; m_perr = 1'b0; loaded = 1'b0;
         consumed = m_valid && r;
         if (m_hunt) begin
            if (m_hit) begin
               m_hunt = 1'b0; m_hit = 1'b0;
               hq.delete(); pq.delete();
               pq.push_back(s);
            end else begin
               hq.push_back(s);
               if (hq.size() > PAT_W) void'(hq.pop_front());
               m_hit = pat_hit();
            end
         end else begin
            pq.push_back(s);
         end
         if (!m_hunt && pq.size() == FRAME_LEN) begin
            w = '0; par = 1'b0;
            for (int i = 0; i < DATA_W; i++) w = {w[DATA_W-2:0], pq[i]};
            foreach (pq[i]) par ^= pq[i];
`ifndef PARITY_CHECK_EN
            par = 1'b0;
`endif
            if (par) m_perr = 1'b1;
            else if (!m_valid || r) begin m_data = w; m_valid = 1'b1; loaded = 1'b1; end
            else m_ovr = 1'b1;
            m_hunt = 1'b1;
            hq.delete(); pq.delete();
         end
         if (consumed && !loaded) m_valid = 1'b0;
      end
   end

   int n_sync = 0, n_ovr = 0, n_perr = 0;

   always @(negedge clk) begin
      if (started) begin
         cmp("sync_found", 32'(sync_found), 32'(m_hunt && m_hit));
         cmp("busy",       32'(busy),       32'(!m_hunt));
         cmp("data_valid", 32'(data_valid), 32'(m_valid));
         cmp("data_out",   32'(data_out),   32'(m_data));
         cmp("overrun",    32'(overrun),    32'(m_ovr));
         cmp("parity_err", 32'(parity_err), 32'(m_perr));
         n_sync += int'(sync_found);
         n_ovr  += int'(overrun);
         n_perr += int'(parity_err);
      end
   end

   task automatic drive(input logic b, input logic r);
      @(negedge clk);
      signal = b;
      data_ready = r;
   endtask

   task automatic send_bits(input logic [31:0] v, input int n, input logic r);
      for (int i = n - 1; i >= 0; i--) drive(v[i], r);
   endtask

   // ready is raised only with the bit whose edge completes the frame
   task automatic send_frame(input logic [7:0] w, input logic r_last, input logic bad_par);
      send_bits(32'b11011, 5, 1'b0);
`ifdef PARITY_CHECK_EN
      send_bits(32'(w), 8, 1'b0);
      drive((^w) ^ bad_par, r_last);
`else
      send_bits(32'(w >> 1), 7, 1'b0);
      drive(w[0], r_last);
`endif
   endtask

   task automatic settle();
      @(negedge clk);
      signal = 1'b0;
      data_ready = 1'b0;
      #1;
   endtask

   task automatic consume();
      drive(1'b0, 1'b1);
      settle();
   endtask

   int s0, o0, p0;

   initial begin
      repeat (2) @(negedge clk);
      #1;
      cmp("reset data_out",   32'(data_out),   32'h0);
      cmp("reset data_valid", 32'(data_valid), 32'h0);
      cmp("reset busy",       32'(busy),       32'h0);
      @(negedge clk);
      rst = 1'b0;
      started = 1'b1;

      // T1 basic frame, word held while not read
      s0 = n_sync;
      send_frame(8'hA5, 1'b0, 1'b0);
      settle();
      cmp("t1 data_out", 32'(data_out), 32'hA5);
      cmp("t1 valid", 32'(data_valid), 32'h1);
      cmp("t1 sync count", 32'(n_sync - s0), 32'h1);
      repeat (3) drive(1'b0, 1'b0);
      settle();
      cmp("t1 held", 32'(data_valid), 32'h1);
      consume();
      cmp("t1 consumed", 32'(data_valid), 32'h0);

      // T2 overlap: 1111011 only matches on its last five bits
      s0 = n_sync;
      send_bits(32'b1111011, 7, 1'b0);
      send_bits(32'h0F, 8, 1'b0);
`ifdef PARITY_CHECK_EN
      drive(1'b0, 1'b0);
`endif
      settle();
      cmp("t2 data_out", 32'(data_out), 32'h0F);
      cmp("t2 sync count", 32'(n_sync - s0), 32'h1);
      consume();

      // T3 overrun on back-to-back frames
      o0 = n_ovr;
      send_frame(8'hA5, 1'b0, 1'b0);
      send_frame(8'h3C, 1'b0, 1'b0);
      settle();
      cmp("t3 overrun count", 32'(n_ovr - o0), 32'h1);
      cmp("t3 data_out", 32'(data_out), 32'hA5);
      consume();

      // T4 read on the completing edge
      o0 = n_ovr;
      send_frame(8'hA5, 1'b0, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b0);
      settle();
      cmp("t4 data_out", 32'(data_out), 32'h3C);
      cmp("t4 valid", 32'(data_valid), 32'h1);
      cmp("t4 overrun count", 32'(n_ovr - o0), 32'h0);

      // T5 reset mid-frame with a word still pending
      send_bits(32'b11011, 5, 1'b0);
      send_bits(32'b1010, 4, 1'b0);
      @(negedge clk);
      #1;
      cmp("t5 busy before", 32'(busy), 32'h1);
      rst = 1'b1;
      #1;
      cmp("t5 data_out", 32'(data_out), 32'h0);
      cmp("t5 valid", 32'(data_valid), 32'h0);
      cmp("t5 busy", 32'(busy), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      send_frame(8'hA5, 1'b0, 1'b0);
      settle();
      cmp("t5 fresh frame", 32'(data_out), 32'hA5);
      consume();

`ifdef PARITY_CHECK_EN
      // T6 parity good and bad
      p0 = n_perr;
      send_frame(8'hA5, 1'b0, 1'b1);
      settle();
      cmp("t6 bad valid", 32'(data_valid), 32'h0);
      cmp("t6 parity_err count", 32'(n_perr - p0), 32'h1);
      send_frame(8'hA5, 1'b0, 1'b0);
      settle();
      cmp("t6 good data", 32'(data_out), 32'hA5);
      cmp("t6 good valid", 32'(data_valid), 32'h1);
      consume();
`else
      p0 = 0;
      cmp("parity_err never", 32'(n_perr), 32'(p0));
`endif

      for (int i = 0; i < 2000; i++)
         drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      settle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
